// File: rtl/img_ctrl_pkg.sv
// rtl/img_ctrl_pkg.sv - shared types and constants for the image frame controller
package img_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ARM,
    ST_CAPTURE,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [1:0] FRAME_RAW  = 2'b00;
  localparam logic [1:0] FRAME_REF  = 2'b01;
  localparam logic [1:0] FRAME_DIFF = 2'b10;

  localparam int ERR_OVF   = 0;
  localparam int ERR_UNEXP = 1;
  localparam int ERR_TMO   = 2;

  // phase is the frame index modulo the re-reference period
  function automatic logic [1:0] frame_type_of(input logic diff, input logic [7:0] ri,
                                               input logic [7:0] phase);
    if (!diff) return FRAME_RAW;
    if (ri != 8'd0 && phase == 8'd0) return FRAME_REF;
    return FRAME_DIFF;
  endfunction

endpackage

// File: rtl/img_frame_ctrl_if.sv
// rtl/img_frame_ctrl_if.sv - controller <-> preprocessing pipeline signal bundle
interface img_frame_ctrl_if;
  logic       frame_start;
  logic       frame_store;
  logic       fifo_overflow;
  logic       unexpected_data;
  logic       unexpected_tlast;
  logic       init_txn;
  logic       diff_en;
  logic       wr2ddr_en;
  logic [1:0] frame_type;

  modport master (
    input  frame_start, frame_store, fifo_overflow, unexpected_data, unexpected_tlast,
    output init_txn, diff_en, wr2ddr_en, frame_type
  );

  modport slave (
    output frame_start, frame_store, fifo_overflow, unexpected_data, unexpected_tlast,
    input  init_txn, diff_en, wr2ddr_en, frame_type
  );
endinterface

// File: rtl/img_frame_timeout.sv
// rtl/img_frame_timeout.sv - loadable down-counter flagging a missing frame_store
module img_frame_timeout (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        load,
  input  logic        run,
  input  logic [31:0] load_val,
  output logic        expired
);

  logic [31:0] cnt_q;

  // loaded with N-1 so the owner sees expiry exactly N cycles after the load edge
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= (load_val == 32'd0) ? 32'd0 : load_val - 32'd1;
    end else if (run && cnt_q != 32'd0) begin
      cnt_q <= cnt_q - 32'd1;
    end
  end

  assign expired = run && (cnt_q <= 32'd1);

endmodule

// File: rtl/img_frame_ctrl.sv
// rtl/img_frame_ctrl.sv - capture-run sequencer for the image preprocessing pipeline
module img_frame_ctrl
  import img_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES    = 16,
  parameter     ENABLE_TIMEOUT = "TRUE"
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    start,
  input  logic                    abort,
  input  logic [15:0]             num_frames,
  input  logic                    diff_mode,
  input  logic [7:0]              ref_interval,
  input  logic [31:0]             timeout_cycles,
  img_frame_ctrl_if.master        pif,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [2:0]              err_code,
  output logic [15:0]             frames_done
);

  state_t      state_q, state_d;
  logic [7:0]  init_cnt_q;
  logic        flush_q;
  logic [15:0] num_q;
  logic        diff_q;
  logic [7:0]  ri_q;
  logic [31:0] tmo_q;
  logic [15:0] start_cnt_q;
  logic [7:0]  phase_q;
  logic [1:0]  frame_type_q;
  logic [15:0] frames_done_q;
  logic        err_q;
  logic [2:0]  err_code_q;

  logic        in_run, start_ok, fs_take, store_take, tmo_load, tmo_expired, tmo_hit;
  logic [2:0]  err_new;
  logic [15:0] fd_next;
  logic [7:0]  phase_nx;

  assign in_run     = (state_q == ST_ARM) || (state_q == ST_CAPTURE);
  assign start_ok   = start && !abort && (state_q == ST_IDLE || state_q == ST_ERROR);
  assign fs_take    = in_run && pif.frame_start && (start_cnt_q < num_q);
  assign store_take = (state_q == ST_CAPTURE) && pif.frame_store;
  assign fd_next    = (store_take && frames_done_q != 16'hFFFF) ? frames_done_q + 16'd1
                                                                : frames_done_q;
  assign phase_nx   = (phase_q + 8'd1 == ri_q) ? 8'd0 : phase_q + 8'd1;
  assign tmo_load   = ((state_q == ST_ARM) && pif.frame_start) || store_take;
  // a frame_store in the expiry cycle still counts as arriving in time
  assign tmo_hit    = (state_q == ST_CAPTURE) && tmo_expired && (tmo_q != 32'd0)
                      && !pif.frame_store;

  always_comb begin
    err_new = 3'b000;
    if (in_run) begin
      err_new[ERR_OVF]   = pif.fifo_overflow;
      err_new[ERR_UNEXP] = pif.unexpected_data | pif.unexpected_tlast;
      err_new[ERR_TMO]   = tmo_hit;
    end
  end

  generate
    if (ENABLE_TIMEOUT == "TRUE") begin : g_tmo
      img_frame_timeout u_tmo (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .load     (tmo_load),
        .run      (state_q == ST_CAPTURE),
        .load_val (tmo_q),
        .expired  (tmo_expired)
      );
    end else begin : g_no_tmo
      assign tmo_expired = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_ERROR: if (start_ok) state_d = ST_INIT;
        ST_INIT:    if (init_cnt_q == 8'(INIT_CYCLES - 1)) state_d = ST_ARM;
        ST_ARM:     if (|err_new) state_d = ST_ERROR;
                    else if (pif.frame_start) state_d = ST_CAPTURE;
        ST_CAPTURE: if (|err_new) state_d = ST_ERROR;
                    else if (store_take && fd_next == num_q) state_d = ST_DONE;
        ST_DONE:    state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      init_cnt_q    <= '0;
      flush_q       <= 1'b0;
      num_q         <= '0;
      diff_q        <= 1'b0;
      ri_q          <= '0;
      tmo_q         <= '0;
      start_cnt_q   <= '0;
      phase_q       <= '0;
      frame_type_q  <= FRAME_RAW;
      frames_done_q <= '0;
      err_q         <= 1'b0;
      err_code_q    <= '0;
    end else begin
      state_q    <= state_d;
      flush_q    <= abort && (state_q != ST_IDLE);
      init_cnt_q <= (state_q == ST_INIT) ? init_cnt_q + 8'd1 : 8'd0;
      if (start_ok) begin
        num_q         <= (num_frames == 16'd0) ? 16'd1 : num_frames;
        diff_q        <= diff_mode;
        ri_q          <= ref_interval;
        tmo_q         <= timeout_cycles;
        start_cnt_q   <= '0;
        phase_q       <= '0;
        frame_type_q  <= FRAME_RAW;
        frames_done_q <= '0;
        err_q         <= 1'b0;
        err_code_q    <= '0;
      end
      // frame 0 is always a reference in difference mode
      if (state_q == ST_INIT && state_d == ST_ARM)
        frame_type_q <= frame_type_of(diff_q, 8'd1, 8'd0);
      if (fs_take) begin
        start_cnt_q  <= start_cnt_q + 16'd1;
        phase_q      <= phase_nx;
        frame_type_q <= frame_type_of(diff_q, ri_q, phase_nx);
      end
      if (store_take) frames_done_q <= fd_next;
      if (|err_new && !abort) begin
        err_q      <= 1'b1;
        err_code_q <= err_code_q | err_new;
      end
    end
  end

  assign pif.init_txn   = (state_q == ST_INIT) | flush_q;
  assign pif.wr2ddr_en  = in_run;
  assign pif.diff_en    = in_run & diff_q;
  assign pif.frame_type = frame_type_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign error          = err_q;
  assign err_code       = err_code_q;
  assign frames_done    = frames_done_q;

endmodule

// File: tb/tb_img_frame_ctrl.sv
// tb/tb_img_frame_ctrl.sv - randomized self-checking bench for img_frame_ctrl
module tb_img_frame_ctrl;

  localparam int INIT_CYC = 16;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] num_frames = '0;
  logic        diff_mode = 1'b0;
  logic [7:0]  ref_interval = '0;
  logic [31:0] timeout_cycles = '0;
  logic        busy, done, error;
  logic [2:0]  err_code;
  logic [15:0] frames_done;

  int n_cmp = 0;
  int n_bad = 0;
  int init_hi = 0;
  int done_seen = 0;

  img_frame_ctrl_if pif ();

  img_frame_ctrl #(.INIT_CYCLES(INIT_CYC), .ENABLE_TIMEOUT("TRUE")) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .start          (start),
    .abort          (abort),
    .num_frames     (num_frames),
    .diff_mode      (diff_mode),
    .ref_interval   (ref_interval),
    .timeout_cycles (timeout_cycles),
    .pif            (pif),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .err_code       (err_code),
    .frames_done    (frames_done)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) begin
    if (pif.init_txn) init_hi <= init_hi + 1;
    if (done) done_seen <= done_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // frame type from the rule: ref at k==0 or every ref_interval frames
  function automatic logic [1:0] exp_type(input int k, input bit dm, input int ri);
    if (!dm) return 2'b00;
    if (k == 0 || (ri != 0 && (k % ri) == 0)) return 2'b01;
    return 2'b10;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clr_in();
    pif.frame_start      = 1'b0;
    pif.frame_store      = 1'b0;
    pif.fifo_overflow    = 1'b0;
    pif.unexpected_data  = 1'b0;
    pif.unexpected_tlast = 1'b0;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic kick(input int n, input bit dm, input int ri, input int to);
    num_frames     = n[15:0];
    diff_mode      = dm;
    ref_interval   = ri[7:0];
    timeout_cycles = to;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_arm();
    int w = 0;
    while (!pif.wr2ddr_en && w < 100) begin
      tick();
      w++;
    end
    chk("arm_reached", pif.wr2ddr_en, 1);
  endtask

  task automatic pulse_start_frame();
    pif.frame_start = 1'b1;
    tick();
    pif.frame_start = 1'b0;
  endtask

  task automatic run_capture(input int n, input bit dm, input int ri, input int maxgap,
                             input bit extra);
    int neff = (n == 0) ? 1 : n;
    int i0 = init_hi;
    int d0 = done_seen;
    int g;
    kick(n, dm, ri, ($urandom_range(0, 1) != 0) ? 0 : 1000);
    wait_arm();
    chk("init_len", init_hi - i0, INIT_CYC);
    for (int k = 0; k < neff; k++) begin
      g = $urandom_range(0, maxgap);
      repeat (g) tick();
      pif.frame_start = 1'b1;
      chk("frame_type", pif.frame_type, exp_type(k, dm, ri));
      chk("diff_en", pif.diff_en, dm);
      tick();
      pif.frame_start = 1'b0;
      if (extra && k == neff - 1) begin
        pulse_start_frame();
        chk("ftype_extra_ignored", pif.frame_type, exp_type(neff, dm, ri));
      end
      repeat (g) tick();
      pif.frame_store = 1'b1;
      tick();
      pif.frame_store = 1'b0;
      if (k < neff - 1) chk("frames_done_run", frames_done, k + 1);
    end
    chk("done_pulse", done, 1);
    chk("frames_done_end", frames_done, neff);
    tick();
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
    chk("done_count", done_seen - d0, 1);
  endtask

  initial begin
    int cyc;
    int d0;
    clr_in();
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_frames_done", frames_done, 0);
    chk("rst_init_txn", pif.init_txn, 0);
    chk("rst_wr2ddr_en", pif.wr2ddr_en, 0);
    chk("rst_diff_en", pif.diff_en, 0);
    chk("rst_frame_type", pif.frame_type, 0);
    aresetn = 1'b1;
    tick();

    run_capture(3, 1'b0, 0, 2, 1'b0);
    run_capture(9, 1'b1, 4, 1, 1'b1);
    for (int r = 0; r < 8; r++)
      run_capture($urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 5), 3,
                  1'($urandom_range(0, 1)));

    // timeout: ERROR is visible 100 cycles after the frame_start cycle
    d0 = done_seen;
    kick(5, 1'b0, 0, 100);
    wait_arm();
    pulse_start_frame();
    cyc = 1;
    while (!error && cyc < 300) begin
      tick();
      cyc++;
    end
    chk("tmo_cycle", cyc, 100);
    chk("tmo_err_code", err_code, 3'b100);
    chk("tmo_wr2ddr_en", pif.wr2ddr_en, 0);
    chk("tmo_busy", busy, 1);
    repeat (5) tick();
    chk("tmo_error_sticky", error, 1);
    kick(2, 1'b1, 0, 0);
    chk("restart_error_clr", error, 0);
    chk("restart_code_clr", err_code, 0);
    chk("restart_init_txn", pif.init_txn, 1);
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_init_busy", busy, 0);
    chk("abort_init_flush", pif.init_txn, 1);
    tick();
    chk("abort_init_flush_end", pif.init_txn, 0);

    // overflow coinciding with frame_store
    kick(4, 1'b0, 0, 0);
    wait_arm();
    pulse_start_frame();
    pif.frame_store = 1'b1;
    tick();
    pif.frame_store = 1'b0;
    chk("ovf_fd_before", frames_done, 1);
    pulse_start_frame();
    tick();
    pif.frame_store   = 1'b1;
    pif.fifo_overflow = 1'b1;
    tick();
    clr_in();
    chk("ovf_error", error, 1);
    chk("ovf_err_code", err_code, 3'b001);
    chk("ovf_frames_done", frames_done, 2);
    chk("ovf_wr2ddr_en", pif.wr2ddr_en, 0);
    chk("ovf_busy", busy, 1);
    start = 1'b1;
    abort = 1'b1;
    tick();
    clr_in();
    chk("stab_busy", busy, 0);
    chk("stab_flush", pif.init_txn, 1);
    tick();
    chk("stab_flush_end", pif.init_txn, 0);
    chk("stab_still_idle", busy, 0);

    // unexpected tlast while armed
    kick(3, 1'b1, 2, 0);
    wait_arm();
    pif.unexpected_tlast = 1'b1;
    tick();
    clr_in();
    chk("utl_err_code", err_code, 3'b010);
    chk("utl_diff_en", pif.diff_en, 0);
    abort = 1'b1;
    tick();
    clr_in();
    tick();

    // abort during CAPTURE
    kick(5, 1'b1, 3, 500);
    wait_arm();
    pulse_start_frame();
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_cap_busy", busy, 0);
    chk("abort_cap_flush", pif.init_txn, 1);
    chk("abort_cap_wr2ddr", pif.wr2ddr_en, 0);
    tick();
    chk("abort_cap_flush_end", pif.init_txn, 0);
    chk("no_done_pulses", done_seen - d0, 0);

    // asynchronous reset mid-capture
    kick(4, 1'b1, 2, 0);
    wait_arm();
    pulse_start_frame();
    pif.frame_store = 1'b1;
    tick();
    pif.frame_store = 1'b0;
    chk("pre_rst_fd", frames_done, 1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_wr2ddr", pif.wr2ddr_en, 0);
    chk("arst_diff_en", pif.diff_en, 0);
    chk("arst_frame_type", pif.frame_type, 0);
    chk("arst_frames_done", frames_done, 0);
    chk("arst_init_txn", pif.init_txn, 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    tick();
    run_capture(3, 1'b1, 2, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
